// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the CPU front-end fetch controller: state encoding,
// instruction width and the default reset PC.
package pc_fetch_ctrl_pkg;

  localparam int unsigned INSTR_WIDTH      = 32;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_FETCH,
    ST_WAIT,
    ST_DISCARD,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch controller bus: redirect input, instruction-memory request/response and
// the valid/ready hand-off to decode, plus the busy status.
interface pc_fetch_ctrl_if #(
  parameter int unsigned OPD_WIDTH = 32,
  parameter int unsigned PC_WIDTH  = 12
);
  import pc_fetch_ctrl_pkg::*;

  logic                   redirect_valid;
  logic [OPD_WIDTH-1:0]   redirect_pc;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_WIDTH-1:0]    imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   if_valid;
  logic                   if_ready;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [OPD_WIDTH-1:0]   if_pc;
  logic [OPD_WIDTH-1:0]   if_pc_plus4;
  logic                   busy;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
           if_pc_plus4, busy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
           if_pc_plus4, busy
  );

endinterface

// File: rtl/pc_fetch_ctrl_fetch_out_reg.sv
// Holding register for the instruction presented to decode; load captures a
// fetched instruction and its PCs, clear only drops the valid flag.
module fetch_out_reg
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   clear_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]    pc_i,
  input  logic [PC_WIDTH-1:0]    pc_plus4_i,
  output logic                   valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [PC_WIDTH-1:0]    pc_plus4_o
);

  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
    end else if (clear_i) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Front-end PC sequencer: owns the PC, issues one instruction fetch at a time,
// hands instructions to decode and squashes fetches made stale by redirects.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned          OPD_WIDTH       = 32,
  parameter int unsigned          PC_WIDTH        = 12,
  parameter logic [OPD_WIDTH-1:0] RESET_PC        = OPD_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned          RST_HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;

  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   redirect_tgt;
  logic                  out_load;
  logic                  out_clear;
  logic                  req_valid;
  logic                  busy;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [PC_WIDTH-1:0]   out_pc_plus4;
  logic                  unused_redirect_bits;

  assign pc_plus4     = pc_q + PC_WIDTH'(4);
  assign redirect_tgt = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_redirect_bits = ^{bus.redirect_pc[OPD_WIDTH-1:PC_WIDTH],
                                  bus.redirect_pc[1:0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_cnt_d = hold_cnt_q;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    req_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      ST_RST_HOLD: begin
        if (hold_cnt_q == CNT_LAST) state_d = ST_FETCH;
        else                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
      ST_FETCH: begin
        req_valid = 1'b1;
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
          if (bus.imem_req_ready) state_d = ST_DISCARD;
        end else if (bus.imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (bus.redirect_valid) begin
          // A response landing together with the redirect is simply dropped.
          pc_d    = redirect_tgt;
          state_d = bus.imem_rsp_valid ? ST_FETCH : ST_DISCARD;
        end else if (bus.imem_rsp_valid) begin
          out_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        busy = 1'b1;
        if (bus.redirect_valid) pc_d = redirect_tgt;
        if (bus.imem_rsp_valid) state_d = ST_FETCH;
      end
      ST_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d      = redirect_tgt;
          out_clear = 1'b1;
          state_d   = ST_FETCH;
        end else if (bus.if_ready) begin
          pc_d      = pc_plus4;
          out_clear = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RST_HOLD;
      pc_q       <= RESET_PC[PC_WIDTH-1:0];
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  fetch_out_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (out_load),
    .clear_i    (out_clear),
    .instr_i    (bus.imem_rsp_data),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (bus.if_valid),
    .instr_o    (bus.if_instr),
    .pc_o       (out_pc),
    .pc_plus4_o (out_pc_plus4)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.busy           = busy;
  assign bus.if_pc          = OPD_WIDTH'(out_pc);
  assign bus.if_pc_plus4    = OPD_WIDTH'(out_pc_plus4);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small instruction-memory model whose
// response data equals the fetched address.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  int   mem_delay = 1;
  logic inj_rsp  = 1'b0;

  logic        pend;
  int          cnt;
  logic [11:0] paddr;

  pc_fetch_ctrl_if #(.OPD_WIDTH(32), .PC_WIDTH(12)) bus ();

  pc_fetch_ctrl #(
    .OPD_WIDTH(32),
    .PC_WIDTH(12),
    .RESET_PC(32'h0),
    .RST_HOLD_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= '0;
    end else begin
      if (pend && cnt == 1) pend <= 1'b0;
      else if (pend)        cnt  <= cnt - 1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend  <= 1'b1;
        cnt   <= mem_delay;
        paddr <= bus.imem_req_addr;
      end
    end
  end

  assign bus.imem_rsp_valid = (pend && cnt == 1) || inj_rsp;
  assign bus.imem_rsp_data  = {20'h0, paddr};

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ifv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.if_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.imem_req_valid, bus.if_valid, bus.busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {bus.imem_req_valid, bus.if_valid, bus.busy}); end
    n_checks++; if ({bus.if_instr, bus.if_pc, bus.if_pc_plus4} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.if_instr, bus.if_pc, bus.if_pc_plus4}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_cycle1: req_valid got %b expected 0", bus.imem_req_valid); end
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 12'h000) begin
      n_fail++; $display("FAIL first_req: valid %b addr %h expected 1 000", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.imem_req_valid, bus.if_valid} !== 3'b100) begin
      n_fail++; $display("FAIL first_wait: busy/req/ifv got %b expected 100", {bus.busy, bus.imem_req_valid, bus.if_valid}); end
    @(negedge clk);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_pc_plus4 !== 32'h4 || bus.if_instr !== 32'h0) begin
      n_fail++; $display("FAIL first_ifv: v %b pc %h pc4 %h instr %h expected 1 0 4 0", bus.if_valid, bus.if_pc, bus.if_pc_plus4, bus.if_instr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 || bus.imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d: v %b pc %h instr %h req %b expected 1 0 0 0", i, bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_req_valid); end
    end
    bus.if_ready = 1'b1;
    last_cyc = cyc;
  endtask

  task automatic test_stream();
    bit ok;
    for (int k = 1; k <= 4; k++) begin
      wait_ifv(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_timeout_%0d: got no if_valid expected one", k); end
      n_checks++; if (bus.if_pc !== 32'(k * 4) || bus.if_instr !== 32'(k * 4) || bus.if_pc_plus4 !== 32'(k * 4 + 4)) begin
        n_fail++; $display("FAIL stream_pc_%0d: pc %h instr %h pc4 %h expected %h", k, bus.if_pc, bus.if_instr, bus.if_pc_plus4, k * 4); end
      n_checks++; if (cyc - last_cyc !== 3) begin
        n_fail++; $display("FAIL stream_rate_%0d: interval %0d expected 3", k, cyc - last_cyc); end
      last_cyc = cyc;
    end
  endtask

  task automatic test_redirect_hold_wrap();
    bit ok;
    wait_ifv(ok);
    n_checks++; if (!ok || bus.if_pc !== 32'h14) begin
      n_fail++; $display("FAIL hold_pre: ok %b pc %h expected 1 014", ok, bus.if_pc); end
    bus.redirect_pc = 32'h0000_0FFC;
    bus.redirect_valid = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 12'hFFC) begin
      n_fail++; $display("FAIL hold_redirect: ifv %b req %b addr %h expected 0 1 ffc", bus.if_valid, bus.imem_req_valid, bus.imem_req_addr); end
    wait_ifv(ok);
    n_checks++; if (!ok || bus.if_pc !== 32'hFFC || bus.if_pc_plus4 !== 32'h0 || bus.if_instr !== 32'hFFC) begin
      n_fail++; $display("FAIL wrap_ifv: pc %h pc4 %h instr %h expected ffc 0 ffc", bus.if_pc, bus.if_pc_plus4, bus.if_instr); end
    wait_req(ok);
    n_checks++; if (!ok || bus.imem_req_addr !== 12'h000) begin
      n_fail++; $display("FAIL wrap_addr: addr %h expected 000", bus.imem_req_addr); end
    wait_ifv(ok);
    n_checks++; if (!ok || bus.if_pc !== 32'h0 || bus.if_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL wrap_next: pc %h pc4 %h expected 0 4", bus.if_pc, bus.if_pc_plus4); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit seen_req;
    mem_delay = 3;
    wait_req(ok);
    n_checks++; if (!ok || bus.imem_req_addr !== 12'h004) begin
      n_fail++; $display("FAIL rw_pre: addr %h expected 004", bus.imem_req_addr); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL rw_wait_busy: got %b expected 1", bus.busy); end
    bus.redirect_pc = 32'h0000_1234;
    bus.redirect_valid = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    mem_delay = 1;
    n_checks++; if (bus.busy !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw_discard: busy %b req %b expected 1 0", bus.busy, bus.imem_req_valid); end
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (bus.if_valid !== 1'b0) begin
        n_fail++; $display("FAIL rw_dropped_%0d: if_valid %b expected 0", i, bus.if_valid); end
      if (bus.imem_req_valid) begin seen_req = 1'b1; break; end
    end
    n_checks++; if (!seen_req || bus.imem_req_addr !== 12'h234) begin
      n_fail++; $display("FAIL rw_addr: seen %b addr %h expected 1 234", seen_req, bus.imem_req_addr); end
    wait_ifv(ok);
    n_checks++; if (!ok || bus.if_pc !== 32'h234 || bus.if_instr !== 32'h234) begin
      n_fail++; $display("FAIL rw_ifv: pc %h instr %h expected 234 234", bus.if_pc, bus.if_instr); end
  endtask

  task automatic test_redirect_fetch();
    bit ok;
    wait_req(ok);
    n_checks++; if (!ok || bus.imem_req_addr !== 12'h238) begin
      n_fail++; $display("FAIL rf_pre: addr %h expected 238", bus.imem_req_addr); end
    bus.redirect_pc = 32'h0000_0102;
    bus.redirect_valid = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rf_discard: busy %b req %b expected 1 0", bus.busy, bus.imem_req_valid); end
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 12'h100 || bus.if_valid !== 1'b0) begin
      n_fail++; $display("FAIL rf_refetch: req %b addr %h ifv %b expected 1 100 0", bus.imem_req_valid, bus.imem_req_addr, bus.if_valid); end
    wait_ifv(ok);
    n_checks++; if (!ok || bus.if_pc !== 32'h100 || bus.if_instr !== 32'h100) begin
      n_fail++; $display("FAIL rf_ifv: pc %h instr %h expected 100 100", bus.if_pc, bus.if_instr); end
    bus.imem_req_ready = 1'b0;
    wait_req(ok);
    n_checks++; if (!ok || bus.imem_req_addr !== 12'h104) begin
      n_fail++; $display("FAIL rn_pre: addr %h expected 104", bus.imem_req_addr); end
    bus.redirect_pc = 32'hFFFF_F20A;
    bus.redirect_valid = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 12'h208 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rn_newaddr: req %b addr %h busy %b expected 1 208 0", bus.imem_req_valid, bus.imem_req_addr, bus.busy); end
    bus.imem_req_ready = 1'b1;
    wait_ifv(ok);
    n_checks++; if (!ok || bus.if_pc !== 32'h208 || bus.if_instr !== 32'h208) begin
      n_fail++; $display("FAIL rn_ifv: pc %h instr %h expected 208 208", bus.if_pc, bus.if_instr); end
  endtask

  task automatic test_rst_in_wait();
    bit ok;
    mem_delay = 3;
    wait_req(ok);
    @(negedge clk);
    n_checks++; if (!ok || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: ok %b busy %b expected 1 1", ok, bus.busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({bus.busy, bus.imem_req_valid, bus.if_valid} !== 3'b000 || {bus.if_instr, bus.if_pc, bus.if_pc_plus4} !== 96'h0) begin
      n_fail++; $display("FAIL rst_async: ctrl %b data %h expected 000 0", {bus.busy, bus.imem_req_valid, bus.if_valid}, {bus.if_instr, bus.if_pc, bus.if_pc_plus4}); end
    @(negedge clk);
    rst = 1'b0;
    mem_delay = 1;
    inj_rsp = 1'b1;
    @(negedge clk);
    inj_rsp = 1'b0;
    n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.if_instr !== 32'h0) begin
      n_fail++; $display("FAIL rst_late_rsp: ifv %b req %b instr %h expected 0 0 0", bus.if_valid, bus.imem_req_valid, bus.if_instr); end
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 12'h000) begin
      n_fail++; $display("FAIL rst_refetch: req %b addr %h expected 1 000", bus.imem_req_valid, bus.imem_req_addr); end
    wait_ifv(ok);
    n_checks++; if (!ok || bus.if_pc !== 32'h0 || bus.if_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL rst_ifv: pc %h pc4 %h expected 0 4", bus.if_pc, bus.if_pc_plus4); end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b0;
    test_reset();
    test_stall();
    test_stream();
    test_redirect_hold_wrap();
    test_redirect_wait();
    test_redirect_fetch();
    test_rst_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
